// File: rtl/bus_event_bridge.sv
// bus_event_bridge
//   Bus-interface bridge for event-driven peripherals. Presents NUM_CH live
//   channel bytes in the CPU window, stores a full channel snapshot in a FIFO
//   each time the peripheral strobes CH_VALID, and raises a maskable interrupt
//   in either per-event or level mode.
//
// Parameters
//   BASE_ADDR  first address of the 32-byte bus window (32-aligned)
//   NUM_CH     channel bytes per snapshot, 1..8
//   FIFO_AW    log2 of FIFO depth in snapshots, 1..7
//
// Ports
//   CLK                  system clock, all logic on posedge
//   RESET                synchronous, active-high
//   BUS_DATA      inout  CPU data bus; driven one cycle after a read, else Z
//   BUS_ADDR      in     CPU address bus
//   BUS_WE        in     CPU write strobe
//   CH_DATA       in     live channel bytes, ch k = [8k+7:8k]
//   CH_VALID      in     one-cycle strobe: snapshot CH_DATA into the FIFO
//   BUS_INTERRUPT_RAISE  out  interrupt request
//   BUS_INTERRUPT_ACK    in   one-cycle acknowledge
//
// Register map (offset from BASE_ADDR)
//   0x00-0x07 R  live channel bytes     0x08-0x0F R  FIFO head bytes
//   0x10 R STATUS {4'b0,RAISE,OVF,full,empty}   0x11 R COUNT
//   0x12 RW CTRL {IRQ_MODE,IRQ_EN}   0x13 W POP   0x14 W CLEAR {flush,clr_ovf}
module bus_event_bridge #(
  parameter logic [7:0]  BASE_ADDR = 8'hA0,
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  logic [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  input  logic [NUM_CH*8-1:0]   CH_DATA,
  input  logic                  CH_VALID,
  output logic                  BUS_INTERRUPT_RAISE,
  input  logic                  BUS_INTERRUPT_ACK
);

  localparam int unsigned      DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  // Storage
  logic [NUM_CH*8-1:0] r_live;
  logic [NUM_CH*8-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic                r_ovf;
  logic [1:0]          r_ctrl;
  logic                r_raise;
  logic [7:0]          r_rdata;
  logic                r_rd_en;

  // Decode
  logic       w_hit;
  logic       w_wr;
  logic       w_rd;
  logic [4:0] w_off;
  logic       w_pop_req;
  logic       w_clr_ovf;
  logic       w_flush;
  logic       w_ctrl_wr;

  // FIFO control
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [FIFO_AW:0] w_count_nxt;
  logic             w_irq_set;

  // Read path
  logic [63:0] w_live_pad;
  logic [63:0] w_head_pad;
  logic [7:0]  w_rdata;
  logic [7:0]  w_status;
  logic        w_unused;

  assign w_hit     = (BUS_ADDR[7:5] == BASE_ADDR[7:5]);
  assign w_off     = BUS_ADDR[4:0];
  assign w_wr      = w_hit & BUS_WE;
  assign w_rd      = w_hit & ~BUS_WE;
  assign w_pop_req = w_wr & (w_off == 5'h13);
  assign w_clr_ovf = w_wr & (w_off == 5'h14) & BUS_DATA[0];
  assign w_flush   = w_wr & (w_off == 5'h14) & BUS_DATA[1];
  assign w_ctrl_wr = w_wr & (w_off == 5'h12);
  assign w_unused  = &{1'b0, BUS_DATA[7:2]};

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A flush discards any same-cycle push or pop. When full, a concurrent
  // valid pop frees the slot the push needs, so both proceed.
  assign w_pop  = w_pop_req & ~w_empty & ~w_flush;
  assign w_push = CH_VALID & (~w_full | w_pop) & ~w_flush;
  assign w_drop = CH_VALID & w_full & ~w_pop & ~w_flush;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (w_flush) begin
      w_count_nxt = '0;
    end
  end

  // Level mode holds off while ACK is high so RAISE visibly drops for one
  // cycle before re-asserting on a still non-empty FIFO.
  assign w_irq_set = r_ctrl[0] &
                     (r_ctrl[1] ? (~w_empty & ~BUS_INTERRUPT_ACK) : w_push);

  // Zero padding to 8 bytes makes offsets at or beyond NUM_CH read as 0.
  assign w_live_pad = 64'(r_live);
  assign w_head_pad = 64'(r_mem[r_rd_ptr]);
  assign w_status   = {4'b0000, r_raise, r_ovf, w_full, w_empty};

  always_comb begin
    w_rdata = '0;
    if (w_off[4:3] == 2'b00) begin
      w_rdata = w_live_pad[{w_off[2:0], 3'b000} +: 8];
    end else if (w_off[4:3] == 2'b01) begin
      w_rdata = w_empty ? '0 : w_head_pad[{w_off[2:0], 3'b000} +: 8];
    end else begin
      unique case (w_off)
        5'h10:   w_rdata = w_status;
        5'h11:   w_rdata = 8'(r_count);
        5'h12:   w_rdata = {6'b000000, r_ctrl};
        default: w_rdata = '0;
      endcase
    end
  end

  // Live bytes and FIFO storage carry no reset.
  always_ff @(posedge CLK) begin
    r_live <= CH_DATA;
    if (w_push) begin
      r_mem[r_wr_ptr] <= CH_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ctrl   <= 2'b01;
      r_raise  <= 1'b0;
      r_rdata  <= '0;
      r_rd_en  <= 1'b0;
    end else begin
      r_rdata <= w_rdata;
      r_rd_en <= w_rd;
      r_count <= w_count_nxt;

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_clr_ovf) begin
        r_ovf <= 1'b0;
      end

      if (w_ctrl_wr) begin
        r_ctrl <= BUS_DATA[1:0];
      end

      if (w_irq_set) begin
        r_raise <= 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
        r_raise <= 1'b0;
      end
    end
  end

  assign BUS_DATA            = r_rd_en ? r_rdata : 'z;
  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule
